// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises and oversamples rx, qualifies the start bit,
// majority-votes each bit at mid-bit and drives the bit clock/data pair for uart_rx.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pad,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [3:0]           frame_len,
  output logic                 rx_bit,
  output logic                 tck,
  output logic                 bit_tick,
  output logic                 busy,
  output logic                 error_start,
  output logic                 frame_error,
  output logic                 break_det
);

  localparam int S  = OVERSAMPLE / 2;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] SM1   = OW'(S - 1);
  localparam logic [OW-1:0] SMID  = OW'(S);
  localparam logic [OW-1:0] SP1   = OW'(S + 1);
  localparam logic [OW-1:0] OSMAX = OW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA} state_e;

  state_e               state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [DIV_WIDTH-1:0] pre_cnt_q, pre_cnt_d, div_q;
  logic [OW-1:0]        os_cnt_q, os_cnt_d, tck_cnt_q;
  logic [1:0]           smp_q;
  logic [3:0]           bit_idx_q, last_idx;
  logic                 zero_q;
  logic                 rx_bit_q, tck_q, bit_tick_q, err_start_q, frame_err_q, break_q;
  logic                 os_tick, fall, vote, decide;

  assign os_tick   = (pre_cnt_q == div_q);
  assign pre_cnt_d = os_tick ? '0 : pre_cnt_q + DIV_WIDTH'(1);
  assign os_cnt_d  = !os_tick ? os_cnt_q : (os_cnt_q == OSMAX) ? '0 : os_cnt_q + OW'(1);
  assign fall      = prev_q & ~sync2_q;
  assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
  assign decide    = os_tick && (os_cnt_q == SP1);
  assign last_idx  = (frame_len < 4'd2) ? 4'd1 : frame_len - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      pre_cnt_q   <= '0;
      div_q       <= '0;
      os_cnt_q    <= '0;
      tck_cnt_q   <= '0;
      smp_q       <= 2'b11;
      bit_idx_q   <= '0;
      zero_q      <= 1'b0;
      rx_bit_q    <= 1'b1;
      tck_q       <= 1'b0;
      bit_tick_q  <= 1'b0;
      err_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      sync1_q     <= rx_pad;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      bit_tick_q  <= 1'b0;
      err_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      if (!enable) begin
        state_q   <= IDLE;
        pre_cnt_q <= '0;
        div_q     <= divisor;
        os_cnt_q  <= '0;
        tck_q     <= 1'b0;
        tck_cnt_q <= '0;
        rx_bit_q  <= 1'b1;
      end else begin
        pre_cnt_q <= pre_cnt_d;
        os_cnt_q  <= os_cnt_d;
        // divisor is only picked up at a wrap so a tick period is never cut short
        if (os_tick) div_q <= divisor;
        if (os_tick && os_cnt_q == SM1)  smp_q[0] <= sync2_q;
        if (os_tick && os_cnt_q == SMID) smp_q[1] <= sync2_q;
        if (tck_q && os_tick) begin
          if (tck_cnt_q == SM1) begin
            tck_q     <= 1'b0;
            tck_cnt_q <= '0;
          end else begin
            tck_cnt_q <= tck_cnt_q + OW'(1);
          end
        end
        case (state_q)
          IDLE: if (fall) begin
            pre_cnt_q <= '0;
            div_q     <= divisor;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            state_q   <= START;
          end
          START: if (decide) begin
            if (vote) begin
              err_start_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              rx_bit_q   <= 1'b0;
              bit_tick_q <= 1'b1;
              tck_q      <= 1'b1;
              tck_cnt_q  <= '0;
              bit_idx_q  <= 4'd1;
              zero_q     <= 1'b1;
              state_q    <= DATA;
            end
          end
          DATA: if (decide) begin
            rx_bit_q   <= vote;
            bit_tick_q <= 1'b1;
            tck_q      <= 1'b1;
            tck_cnt_q  <= '0;
            // leave mid stop bit so the next start edge is caught
            if (bit_idx_q == last_idx) begin
              frame_err_q <= ~vote;
              break_q     <= zero_q & ~vote;
              state_q     <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              zero_q    <= zero_q & ~vote;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_bit      = rx_bit_q;
  assign tck         = tck_q;
  assign bit_tick    = bit_tick_q;
  assign busy        = (state_q != IDLE);
  assign error_start = err_start_q;
  assign frame_error = frame_err_q;
  assign break_det   = break_q;

endmodule
